fp_minmax_unit: RTL and testbench
=================================

Name: fp_minmax_unit

Overview:
- Multi-lane, pipelined IEEE-754 single-precision min/max unit for the SIMT floating-point datapath; next generation of the single-lane fixed-latency max block.
- Adds a min/max mode select, per-lane masking and RISC-V fmin/fmax NaN and signed-zero semantics with an invalid flag.
- Adds a valid/ready elastic pipeline with a tag carried alongside each operation.

Parameters:
- LANES, 4, number of independent 32-bit lanes; must be ≥1.
- LATENCY, 2, pipeline stages from accept to out_valid with no stall; must be ≥1.
- TAG_W, 8, width of the opaque tag carried with each operation.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept this cycle.
- in_op  in  1  0 = MIN, 1 = MAX.
- in_mask  in  LANES  per-lane enable.
- in_a  in  LANES*32  operand A; lane i is bits [32i+31:32i].
- in_b  in  LANES*32  operand B; same packing as in_a.
- in_tag  in  TAG_W  opaque tag, returned unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_q  out  LANES*32  per-lane results.
- out_nv  out  LANES  per-lane invalid-operation flag.
- out_tag  out  TAG_W  tag of the result on out_q.

Behaviour:
- Reset (reset low, asynchronous): all stage valid bits clear. out_valid=0, out_q=0, out_nv=0, out_tag=0. in_ready=1 from the first cycle after reset deasserts.
- Accept when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Pipeline: LATENCY register stages S0..S(L-1). Each stage holds a valid bit plus q, nv and tag for every lane.
- Stall rule: stage k loads when it is empty or stage k+1 loads that cycle. The last stage loads when it is empty or out_ready=1.
- in_ready = S0 empty OR S0 loads this cycle (bubble-collapsing, combinational from out_ready).
- Throughput: one operation per cycle when never stalled. Minimum latency is exactly LATENCY cycles from accept to out_valid.
- Stalled stages hold their contents unchanged. No operation is dropped or duplicated.
- Compare is combinational before S0. Later stages are pure delay registers.
- Per-lane compare, in order of precedence:
  - Mask bit 0: q=0, nv=0.
  - Both operands NaN: q=0x7FC00000 (canonical NaN).
  - Exactly one operand NaN: q = the non-NaN operand.
  - Signed zeros: -0.0 is treated as less than +0.0. So MIN(+0,-0)=0x80000000 and MAX(+0,-0)=0x00000000.
  - Otherwise: ordered comparison on sign-magnitude. Equal values return operand a.
  - nv=1 if either operand is a signalling NaN (exponent all ones, mantissa non-zero, bit 22 = 0), including when both are NaN. Masked lanes always have nv=0.
- Denormals are compared exactly; no flush-to-zero.
- Output register contents are don't-care when out_valid=0, but held stable while out_valid=1 && out_ready=0.
- Reset asserted mid-operation: all in-flight operations are discarded and no partial result appears after release.

Decomposition:
- Shared fp package: FP32 field widths; CANONICAL_NAN = 0x7FC00000; the op encoding (MIN=0, MAX=1); is_nan / is_snan / is_zero helper functions.
- Sub-module fp_minmax_lane: combinational single-lane compare producing q and nv. Instantiate it LANES times inside a generate loop.
- The elastic stage pipeline stays in the top-level module.

Test Plan:
- Basic, LANES=4, LATENCY=2, out_ready=1: MAX a=(1.0, -2.0, 3.5, 0.0) b=(2.0, -1.0, 3.5, -0.0) -> after exactly 2 cycles q=(0x40000000, 0xBF800000, 0x40600000, 0x00000000), nv=0, tag echoed. The same inputs with MIN -> (0x3F800000, 0xC0000000, 0x40600000, 0x80000000).
- NaN handling, MIN:
  - a=0x7FC00000, b=0x40400000 -> q=0x40400000, nv=0.
  - a=0x7F800001 (sNaN), b=0x3F800000 -> q=0x3F800000, nv=1.
  - a=0x7FA00000, b=0xFFC00001 -> q=0x7FC00000, nv=1.
- Mask: in_mask=4'b0101 with sNaN in every lane -> lanes 1 and 3 give q=0, nv=0; lanes 0 and 2 give nv=1.
- Backpressure: issue 5 back-to-back ops with tags 1..5 while out_ready=0 -> in_ready drops after LATENCY accepts. Raise out_ready -> tags emerge 1,2,3,4,5 in order, one per cycle, with no loss or duplication.
- Throughput: 100 random ops with out_ready=1 -> in_ready stays 1 throughout; results match a reference model with a constant LATENCY-cycle offset.
- Reset mid-flight: accept 2 ops, assert reset for 1 cycle -> out_valid=0 immediately. After release, no stale result appears and the next op completes in LATENCY cycles.

Source files
------------

// File: rtl/fp_minmax_unit_pkg.sv
// Shared FP32 definitions for the min/max datapath: field widths, canonical NaN,
// op encoding and the classification / ordering helpers used by every lane.
package fp_minmax_unit_pkg;

    localparam int FP_W  = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam logic [FP_W-1:0] CANONICAL_NAN = 32'h7FC0_0000;

    typedef enum logic {
        OP_MIN = 1'b0,
        OP_MAX = 1'b1
    } op_e;

    function automatic logic is_nan(input logic [FP_W-1:0] x);
        return (&x[FP_W-2 -: EXP_W]) && (|x[MAN_W-1:0]);
    endfunction

    // Signalling NaN: quiet bit (mantissa MSB) clear.
    function automatic logic is_snan(input logic [FP_W-1:0] x);
        return is_nan(x) && !x[MAN_W-1];
    endfunction

    function automatic logic is_zero(input logic [FP_W-1:0] x);
        return x[FP_W-2:0] == '0;
    endfunction

    // Strict a < b on non-NaN sign-magnitude values; -0 < +0 falls out of the sign test.
    function automatic logic fp_lt(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
        if (a[FP_W-1] != b[FP_W-1]) begin
            return a[FP_W-1];
        end else if (!a[FP_W-1]) begin
            return a[FP_W-2:0] < b[FP_W-2:0];
        end else begin
            return a[FP_W-2:0] > b[FP_W-2:0];
        end
    endfunction

endpackage

// File: rtl/fp_minmax_lane.sv
// Single-lane combinational fmin/fmax with NaN propagation, signed-zero ordering
// and invalid flag for signalling NaN inputs.
module fp_minmax_lane
    import fp_minmax_unit_pkg::*;
(
    input  logic            en_i,
    input  op_e             op_i,
    input  logic [FP_W-1:0] a_i,
    input  logic [FP_W-1:0] b_i,
    output logic [FP_W-1:0] q_o,
    output logic            nv_o
);

    logic a_nan;
    logic b_nan;
    logic a_lt_b;
    logic b_lt_a;

    assign a_nan  = is_nan(a_i);
    assign b_nan  = is_nan(b_i);
    assign a_lt_b = fp_lt(a_i, b_i);
    assign b_lt_a = fp_lt(b_i, a_i);

    // Ties keep operand a, so only a strict win selects b.
    always_comb begin
        q_o  = '0;
        nv_o = 1'b0;
        if (en_i) begin
            nv_o = is_snan(a_i) || is_snan(b_i);
            if (a_nan && b_nan) begin
                q_o = CANONICAL_NAN;
            end else if (a_nan) begin
                q_o = b_i;
            end else if (b_nan) begin
                q_o = a_i;
            end else if (op_i == OP_MIN) begin
                q_o = b_lt_a ? b_i : a_i;
            end else begin
                q_o = a_lt_b ? b_i : a_i;
            end
        end
    end

endmodule

// File: rtl/fp_minmax_unit.sv
// Multi-lane FP32 min/max: combinational lane compare feeding a LATENCY-deep
// elastic pipeline that carries per-lane results, invalid flags and a tag.
module fp_minmax_unit
    import fp_minmax_unit_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_op,
    input  logic [LANES-1:0]      in_mask,
    input  logic [LANES*FP_W-1:0] in_a,
    input  logic [LANES*FP_W-1:0] in_b,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*FP_W-1:0] out_q,
    output logic [LANES-1:0]      out_nv,
    output logic [TAG_W-1:0]      out_tag
);

    localparam int DW = LANES * FP_W;

    // Handshake: a transfer happens on a rising edge where valid && ready; valid never
    // waits on ready, and offered data is held while valid && !ready.

    logic [DW-1:0]    cmp_q;
    logic [LANES-1:0] cmp_nv;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fp_minmax_lane u_lane (
            .en_i (in_mask[i]),
            .op_i (op_e'(in_op)),
            .a_i  (in_a[i*FP_W +: FP_W]),
            .b_i  (in_b[i*FP_W +: FP_W]),
            .q_o  (cmp_q[i*FP_W +: FP_W]),
            .nv_o (cmp_nv[i])
        );
    end

    logic [LATENCY-1:0] stage_vld;
    logic [LATENCY-1:0] stage_load;
    logic [DW-1:0]      stage_q   [LATENCY];
    logic [LANES-1:0]   stage_nv  [LATENCY];
    logic [TAG_W-1:0]   stage_tag [LATENCY];
    logic               load_carry;

    // A stage loads when empty or when its successor drains this cycle.
    always_comb begin
        stage_load = '0;
        load_carry = out_ready;
        for (int k = LATENCY - 1; k >= 0; k--) begin
            stage_load[k] = !stage_vld[k] || load_carry;
            load_carry    = stage_load[k];
        end
    end

    assign in_ready = stage_load[0];

    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        logic             vld_d;
        logic [DW-1:0]    q_d;
        logic [LANES-1:0] nv_d;
        logic [TAG_W-1:0] tag_d;
        logic             vld_q;
        logic [DW-1:0]    q_q;
        logic [LANES-1:0] nv_q;
        logic [TAG_W-1:0] tag_q;

        if (k == 0) begin : g_head
            assign vld_d = in_valid;
            assign q_d   = cmp_q;
            assign nv_d  = cmp_nv;
            assign tag_d = in_tag;
        end else begin : g_body
            assign vld_d = stage_vld[k-1];
            assign q_d   = stage_q[k-1];
            assign nv_d  = stage_nv[k-1];
            assign tag_d = stage_tag[k-1];
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                vld_q <= 1'b0;
                q_q   <= '0;
                nv_q  <= '0;
                tag_q <= '0;
            end else if (stage_load[k]) begin
                vld_q <= vld_d;
                q_q   <= q_d;
                nv_q  <= nv_d;
                tag_q <= tag_d;
            end
        end

        assign stage_vld[k] = vld_q;
        assign stage_q[k]   = q_q;
        assign stage_nv[k]  = nv_q;
        assign stage_tag[k] = tag_q;
    end

    assign out_valid = stage_vld[LATENCY-1];
    assign out_q     = stage_q[LATENCY-1];
    assign out_nv    = stage_nv[LATENCY-1];
    assign out_tag   = stage_tag[LATENCY-1];

endmodule

// File: tb/tb_fp_minmax_unit.sv
// Scoreboard bench for fp_minmax_unit: directed vectors, backpressure, random
// traffic against a real-valued reference model, and reset mid-flight.
module tb_fp_minmax_unit;

    localparam int LANES   = 4;
    localparam int LATENCY = 2;
    localparam int TAG_W   = 8;
    localparam int DW      = LANES * 32;
    localparam int EW      = DW + LANES + TAG_W;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic             in_valid;
    logic             in_ready;
    logic             in_op;
    logic [LANES-1:0] in_mask;
    logic [DW-1:0]    in_a;
    logic [DW-1:0]    in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_q;
    logic [LANES-1:0] out_nv;
    logic [TAG_W-1:0] out_tag;

    fp_minmax_unit #(.LANES(LANES), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_mask   (in_mask),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_nv    (out_nv),
        .out_tag   (out_tag)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int            cyc_q[$];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            lat_chk = 1'b0;
    bit            rand_ready = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [EW-1:0] got, input logic [EW-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic real fp_val(input logic [31:0] x);
        int  e = int'(x[30:23]);
        real m = real'(x[22:0]);
        real s = 1.0;
        int  p;
        if (e == 0) begin
            p = -149;
        end else begin
            m = m + 8388608.0;
            p = e - 150;
        end
        for (int i = 0; i < p; i++) s = s * 2.0;
        for (int i = 0; i < -p; i++) s = s / 2.0;
        return x[31] ? -(m * s) : (m * s);
    endfunction

    task automatic ref_lane(input bit op, input bit en, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] q, output logic nv);
        bit  an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        bit  bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        real va;
        real vb;
        q  = 32'd0;
        nv = 1'b0;
        if (en) begin
            nv = (an && !a[22]) || (bn && !b[22]);
            if (an && bn) q = 32'h7FC00000;
            else if (an) q = b;
            else if (bn) q = a;
            else begin
                va = fp_val(a);
                vb = fp_val(b);
                if (va == 0.0 && vb == 0.0 && a[31] != b[31]) begin
                    if (!op) q = a[31] ? a : b;
                    else     q = a[31] ? b : a;
                end else if (!op) begin
                    q = (vb < va) ? b : a;
                end else begin
                    q = (vb > va) ? b : a;
                end
            end
        end
    endtask

    task automatic ref_op(input bit op, input logic [LANES-1:0] mask, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [TAG_W-1:0] tag, output logic [EW-1:0] e);
        logic [DW-1:0]    q;
        logic [LANES-1:0] nv;
        logic [31:0]      ql;
        logic             nvl;
        for (int l = 0; l < LANES; l++) begin
            ref_lane(op, mask[l], a[l*32 +: 32], b[l*32 +: 32], ql, nvl);
            q[l*32 +: 32] = ql;
            nv[l]         = nvl;
        end
        e = {q, nv, tag};
    endtask

    function automatic logic [31:0] rand_fp(input logic [31:0] other);
        logic [22:0] man;
        case ($urandom_range(0, 9))
            4: return {1'($urandom_range(0, 1)), 31'd0};
            5: return other;
            6: return other ^ 32'h80000000;
            7: return {1'($urandom_range(0, 1)), 8'h00, 23'($urandom_range(1, 15))};
            8: begin
                man = 23'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 1) man = man | 23'h400000;
                return {1'($urandom_range(0, 1)), 8'hFF, man};
            end
            default: return 32'($urandom);
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input bit op, input logic [LANES-1:0] mask, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [TAG_W-1:0] tag);
        @(negedge clock);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        in_op    = op;
        in_mask  = mask;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        #1;
    endtask

    task automatic accept(input logic [EW-1:0] e);
        int w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clock);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            #1;
            w++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready stuck at 0, expected 1 within 50 cycles");
        end else begin
            exp_q.push_back(e);
            cyc_q.push_back(cyc + LATENCY);
        end
    endtask

    task automatic send(input bit op, input logic [LANES-1:0] mask, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [TAG_W-1:0] tag);
        logic [EW-1:0] e;
        ref_op(op, mask, a, b, tag, e);
        drive(op, mask, a, b, tag);
        accept(e);
    endtask

    task automatic send_exp(input bit op, input logic [LANES-1:0] mask, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input logic [TAG_W-1:0] tag, input logic [EW-1:0] e);
        drive(op, mask, a, b, tag);
        accept(e);
    endtask

    task automatic idle();
        @(negedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic rand_send(input logic [TAG_W-1:0] tag);
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        for (int l = 0; l < LANES; l++) begin
            a[l*32 +: 32] = rand_fp(32'($urandom));
            b[l*32 +: 32] = rand_fp(a[l*32 +: 32]);
        end
        send(1'($urandom_range(0, 1)), LANES'($urandom), a, b, tag);
    endtask

    // ---------------- monitor ----------------
    logic          prev_stall = 1'b0;
    logic [EW-1:0] prev_out;
    logic [EW-1:0] mon_e;
    int            mon_c;

    always begin
        @(negedge clock);
        #4;
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", EW'(out_valid), EW'(1));
                chk("hold_data", {out_q, out_nv, out_tag}, prev_out);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: tag %h appeared, expected no output", out_tag);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_c = cyc_q.pop_front();
                    chk("result", {out_q, out_nv, out_tag}, mon_e);
                    if (lat_chk) chk("latency_cycle", EW'(cyc), EW'(mon_c));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_q, out_nv, out_tag};
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        in_valid  = 1'b0;
        in_op     = 1'b0;
        in_mask   = '0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        repeat (3) @(negedge clock);
        #1;
        chk("reset_out_valid", EW'(out_valid), EW'(0));
        chk("reset_out_data", {out_q, out_nv, out_tag}, EW'(0));
        reset = 1'b1;
        @(negedge clock);
        #2;
        chk("in_ready_after_reset", EW'(in_ready), EW'(1));

        // Directed basic, NaN and mask vectors with literal expectations.
        lat_chk = 1'b1;
        send_exp(1'b1, 4'hF,
                 {32'h00000000, 32'h40600000, 32'hC0000000, 32'h3F800000},
                 {32'h80000000, 32'h40600000, 32'hBF800000, 32'h40000000}, 8'h11,
                 {32'h00000000, 32'h40600000, 32'hBF800000, 32'h40000000, 4'b0000, 8'h11});
        send_exp(1'b0, 4'hF,
                 {32'h00000000, 32'h40600000, 32'hC0000000, 32'h3F800000},
                 {32'h80000000, 32'h40600000, 32'hBF800000, 32'h40000000}, 8'h12,
                 {32'h80000000, 32'h40600000, 32'hC0000000, 32'h3F800000, 4'b0000, 8'h12});
        send_exp(1'b0, 4'hF,
                 {32'h00000001, 32'h7FA00000, 32'h7F800001, 32'h7FC00000},
                 {32'h00000002, 32'hFFC00001, 32'h3F800000, 32'h40400000}, 8'h13,
                 {32'h00000001, 32'h7FC00000, 32'h3F800000, 32'h40400000, 4'b0110, 8'h13});
        send_exp(1'b1, 4'b0101,
                 {4{32'h7F800001}}, {4{32'h3F800000}}, 8'h14,
                 {32'h00000000, 32'h3F800000, 32'h00000000, 32'h3F800000, 4'b0101, 8'h14});
        idle();
        repeat (LATENCY + 2) @(negedge clock);

        // Backpressure: fill the pipe, then release and stream tags 1..5.
        lat_chk = 1'b0;
        #1;
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 4'hF, {4{32'h3F800000}}, {4{32'h40000000}}, TAG_W'(i));
            if (i == LATENCY + 1) begin
                chk("bp_in_ready_stalled", EW'(in_ready), EW'(0));
                out_ready = 1'b1;
                #1;
                chk("bp_in_ready_collapse", EW'(in_ready), EW'(1));
            end else begin
                chk("bp_in_ready", EW'(in_ready), EW'(1));
            end
            if (i > LATENCY) chk("bp_stream_valid", EW'(out_valid), EW'(1));
            accept({{4{32'h40000000}}, 4'b0000, TAG_W'(i)});
        end
        idle();
        #1;
        chk("bp_stream_valid", EW'(out_valid), EW'(1));
        repeat (LATENCY - 1) begin
            @(negedge clock);
            #2;
            chk("bp_stream_valid", EW'(out_valid), EW'(1));
        end
        repeat (LATENCY + 2) @(negedge clock);

        // Full-rate random traffic with a fixed latency.
        lat_chk = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rand_send(TAG_W'(i));
            chk("tp_in_ready", EW'(in_ready), EW'(1));
        end
        idle();
        repeat (LATENCY + 2) @(negedge clock);

        // Random traffic under random backpressure.
        lat_chk    = 1'b0;
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) rand_send(TAG_W'($urandom));
        idle();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (LATENCY + 4) @(negedge clock);

        // Reset with operations in flight.
        #1;
        out_ready = 1'b0;
        rand_send(8'hA1);
        rand_send(8'hA2);
        idle();
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_reset_out_valid", EW'(out_valid), EW'(0));
        chk("mid_reset_out_data", {out_q, out_nv, out_tag}, EW'(0));
        exp_q.delete();
        cyc_q.delete();
        @(negedge clock);
        #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clock);
            #2;
            chk("post_reset_quiet", EW'(out_valid), EW'(0));
        end
        lat_chk = 1'b1;
        rand_send(8'hB0);
        idle();

        // Drain the scoreboard with a bounded wait.
        for (int w = 0; w < 100 && exp_q.size() != 0; w++) @(negedge clock);
        repeat (2) @(negedge clock);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
